controlador_de_carga: RTL and testbench



---
 rtl/controlador_de_carga.sv | 196 +++++++++++++++++++
 tb/tb_controlador_de_carga.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/controlador_de_carga.sv
// controlador_de_carga
// ---------------------------------------------------------------------------
// Boot / program-load sequencer.
//
// The processor is held in reset while program words arrive on a valid/ready
// handshake. Each word is written to consecutive instruction-memory addresses,
// starting at 0. After the last write, the block waits a guard interval. It
// then releases the processor. From EXEC, a new legal start reloads the
// program.
//
// Ports
//   clock        : system clock, rising edge
//   resetn       : asynchronous active-low reset
//   start        : request a (re)load, sampled on every rising edge
//   n_words      : number of words to load, latched when start is accepted
//   in_valid     : in_data holds a valid word
//   in_data      : program word
//   in_ready     : block accepts a word this cycle (high only in CARGA)
//   mem_wr       : instruction-memory write enable (registered)
//   mem_addr     : write address (registered)
//   mem_data     : write data (registered)
//   proc_resetn  : active-low processor reset (registered)
//   busy         : load or guard interval in progress
//   done         : program loaded, processor running
//   erro         : last start carried an illegal n_words (sticky)
// ---------------------------------------------------------------------------
module controlador_de_carga #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int MAX_WORDS   = 256,
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] n_words,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              proc_resetn,
  output logic              busy,
  output logic              done,
  output logic              erro
);

  localparam logic [1:0] OCIOSO = 2'd0;
  localparam logic [1:0] CARGA  = 2'd1;
  localparam logic [1:0] ESPERA = 2'd2;
  localparam logic [1:0] EXEC   = 2'd3;

  // The hold counter runs from 0 to HOLD_CYCLES-1.
  // One extra bit in the size compare lets MAX_WORDS reach 2**ADDR_W.
  localparam int               HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [ADDR_W:0]   MAX_LEGAL = (ADDR_W + 1)'(MAX_WORDS);

  logic [1:0]        state_q,       state_d;
  logic [ADDR_W-1:0] count_q,       count_d;
  logic [ADDR_W-1:0] addr_q,        addr_d;
  logic [HOLD_W-1:0] hold_q,        hold_d;
  logic              mem_wr_q,      mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q,    mem_addr_d;
  logic [DATA_W-1:0] mem_data_q,    mem_data_d;
  logic              proc_resetn_q, proc_resetn_d;
  logic              busy_q,        busy_d;
  logic              done_q,        done_d;
  logic              erro_q,        erro_d;

  logic sizeLegal;
  logic handshake;
  logic lastWord;

  assign sizeLegal = (n_words != '0) && ({1'b0, n_words} <= MAX_LEGAL);

  // in_ready depends only on the state, never on an input.
  assign in_ready  = (state_q == CARGA);
  assign handshake = in_ready && in_valid;

  // addr_q never goes past count_q-1. So this compare also stops the address
  // from wrapping.
  assign lastWord  = (addr_q == (count_q - ADDR_W'(1)));

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    addr_d        = addr_q;
    hold_d        = hold_q;
    mem_wr_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_data_d    = mem_data_q;
    proc_resetn_d = proc_resetn_q;
    busy_d        = busy_q;
    done_d        = done_q;
    erro_d        = erro_q;

    case (state_q)
      OCIOSO: begin
        if (start) begin
          if (sizeLegal) begin
            count_d = n_words;
            addr_d  = '0;
            erro_d  = 1'b0;
            busy_d  = 1'b1;
            state_d = CARGA;
          end else begin
            erro_d = 1'b1;
          end
        end
      end

      CARGA: begin
        // A start request during the load is ignored.
        if (handshake) begin
          mem_wr_d   = 1'b1;
          mem_addr_d = addr_q;
          mem_data_d = in_data;
          addr_d     = addr_q + ADDR_W'(1);
          if (lastWord) begin
            hold_d  = '0;
            state_d = ESPERA;
          end
        end
      end

      ESPERA: begin
        // The final write lands during the first ESPERA cycle. The processor
        // is released HOLD_CYCLES edges after ESPERA is entered.
        if (hold_q == HOLD_LAST) begin
          proc_resetn_d = 1'b1;
          done_d        = 1'b1;
          busy_d        = 1'b0;
          state_d       = EXEC;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end

      default: begin
        // EXEC: a legal start puts the processor back in reset on this edge.
        if (start) begin
          if (sizeLegal) begin
            count_d       = n_words;
            addr_d        = '0;
            erro_d        = 1'b0;
            busy_d        = 1'b1;
            done_d        = 1'b0;
            proc_resetn_d = 1'b0;
            state_d       = CARGA;
          end else begin
            erro_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= OCIOSO;
      count_q       <= '0;
      addr_q        <= '0;
      hold_q        <= '0;
      mem_wr_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_q    <= '0;
      proc_resetn_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      erro_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      addr_q        <= addr_d;
      hold_q        <= hold_d;
      mem_wr_q      <= mem_wr_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_q    <= mem_data_d;
      proc_resetn_q <= proc_resetn_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      erro_q        <= erro_d;
    end
  end

  assign mem_wr      = mem_wr_q;
  assign mem_addr    = mem_addr_q;
  assign mem_data    = mem_data_q;
  assign proc_resetn = proc_resetn_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign erro        = erro_q;

endmodule

// File: tb/tb_controlador_de_carga.sv
// tb_controlador_de_carga
// ---------------------------------------------------------------------------
// Directed bench for the program-load sequencer. Inputs change 1 ns after a
// rising edge. Outputs are read at that same point, so each read shows the
// state left by the edge just taken. A negedge monitor logs every memory
// write, which catches stray or missing mem_wr pulses.
// ---------------------------------------------------------------------------
module tb_controlador_de_carga;

  logic        clock;
  logic        resetn;
  logic        start;
  logic [15:0] n_words;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        proc_resetn;
  logic        busy;
  logic        done;
  logic        erro;

  int checks   = 0;
  int failures = 0;

  logic [15:0] logAddr[$];
  logic [15:0] logData[$];

  controlador_de_carga #(
    .DATA_W(16), .ADDR_W(16), .MAX_WORDS(256), .HOLD_CYCLES(4)
  ) dut (
    .clock(clock), .resetn(resetn), .start(start), .n_words(n_words),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data(mem_data),
    .proc_resetn(proc_resetn), .busy(busy), .done(done), .erro(erro)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Write logger. It samples in mid-cycle, away from the active edge.
  always @(negedge clock) begin
    if (resetn && mem_wr) begin
      logAddr.push_back(mem_addr);
      logData.push_back(mem_data);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Pulses start with the given size for exactly one edge.
  task automatic applyStimulus(input logic [15:0] n);
    start   = 1'b1;
    n_words = n;
    step();
    start   = 1'b0;
  endtask

  // Entry to ESPERA has just been sampled. The processor must stay in reset
  // for three more edges and be released on the fourth.
  task automatic waitRelease(input string tag);
    for (int i = 1; i <= 4; i++) begin
      step();
      checkOutput($sformatf("%s_prst%0d", tag, i), proc_resetn, (i == 4) ? 1 : 0);
    end
    checkOutput({tag, "_done"}, done, 1);
    checkOutput({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int badSeq;
    resetn   = 1'b0;
    start    = 1'b0;
    n_words  = '0;
    in_valid = 1'b0;
    in_data  = '0;

    // Reset values
    step();
    step();
    checkOutput("rst_prst",  proc_resetn, 0);
    checkOutput("rst_ready", in_ready, 0);
    checkOutput("rst_busy",  busy, 0);
    checkOutput("rst_done",  done, 0);
    checkOutput("rst_erro",  erro, 0);
    checkOutput("rst_wr",    mem_wr, 0);
    resetn = 1'b1;
    step();

    // Illegal sizes from OCIOSO
    applyStimulus(16'd0);
    checkOutput("ill0_erro",  erro, 1);
    checkOutput("ill0_ready", in_ready, 0);
    checkOutput("ill0_busy",  busy, 0);
    step();
    checkOutput("ill0_stay",  in_ready, 0);
    applyStimulus(16'd257);
    checkOutput("ill257_erro", erro, 1);
    checkOutput("ill257_busy", busy, 0);

    // Burst load of three words
    logAddr.delete();
    logData.delete();
    applyStimulus(16'd3);
    checkOutput("b_erro_clr", erro, 0);
    checkOutput("b_busy",     busy, 1);
    checkOutput("b_ready",    in_ready, 1);
    in_valid = 1'b1;
    in_data  = 16'h00A1;
    step();
    checkOutput("b_wr0",   mem_wr, 1);
    checkOutput("b_addr0", mem_addr, 0);
    checkOutput("b_data0", mem_data, 16'h00A1);
    in_data = 16'h00B2;
    step();
    checkOutput("b_addr1", mem_addr, 1);
    checkOutput("b_data1", mem_data, 16'h00B2);
    in_data = 16'h00C3;
    step();
    checkOutput("b_wr2",    mem_wr, 1);
    checkOutput("b_addr2",  mem_addr, 2);
    checkOutput("b_data2",  mem_data, 16'h00C3);
    checkOutput("b_rdy_lo", in_ready, 0);
    in_valid = 1'b0;
    waitRelease("b");
    checkOutput("b_nwr", logAddr.size(), 3);

    // Reload of one word from EXEC, with a start during CARGA
    logAddr.delete();
    logData.delete();
    applyStimulus(16'd1);
    checkOutput("r_prst", proc_resetn, 0);
    checkOutput("r_done", done, 0);
    checkOutput("r_busy", busy, 1);
    start    = 1'b1;
    n_words  = 16'd5;
    in_valid = 1'b1;
    in_data  = 16'h0055;
    step();
    start    = 1'b0;
    in_valid = 1'b0;
    checkOutput("r_addr",     mem_addr, 0);
    checkOutput("r_data",     mem_data, 16'h0055);
    checkOutput("r_ign_rdy",  in_ready, 0);
    checkOutput("r_ign_erro", erro, 0);
    waitRelease("r");
    checkOutput("r_nwr", logAddr.size(), 1);

    // Illegal size while running
    applyStimulus(16'd257);
    checkOutput("ex_erro", erro, 1);
    checkOutput("ex_prst", proc_resetn, 1);
    checkOutput("ex_done", done, 1);

    // Bubbles: valid only in CARGA cycles 2 and 5
    logAddr.delete();
    logData.delete();
    applyStimulus(16'd2);
    checkOutput("bub_erro", erro, 0);
    step();
    checkOutput("bub_c1", mem_wr, 0);
    in_valid = 1'b1;
    in_data  = 16'h1111;
    step();
    in_valid = 1'b0;
    checkOutput("bub_wr0",   mem_wr, 1);
    checkOutput("bub_addr0", mem_addr, 0);
    step();
    checkOutput("bub_c3",      mem_wr, 0);
    checkOutput("bub_hold_a",  mem_addr, 0);
    checkOutput("bub_hold_d",  mem_data, 16'h1111);
    step();
    checkOutput("bub_c4", mem_wr, 0);
    in_valid = 1'b1;
    in_data  = 16'h2222;
    step();
    in_valid = 1'b0;
    checkOutput("bub_wr1",   mem_wr, 1);
    checkOutput("bub_addr1", mem_addr, 1);
    checkOutput("bub_data1", mem_data, 16'h2222);
    waitRelease("bub");
    checkOutput("bub_nwr", logAddr.size(), 2);

    // Largest legal load: 256 words
    logAddr.delete();
    logData.delete();
    applyStimulus(16'd256);
    checkOutput("m_erro", erro, 0);
    in_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_data = 16'h1000 + 16'(i);
      step();
    end
    in_valid = 1'b0;
    checkOutput("m_rdy_lo", in_ready, 0);
    waitRelease("m");
    checkOutput("m_nwr", logAddr.size(), 256);
    if (logAddr.size() == 256) begin
      checkOutput("m_last_addr", logAddr[255], 16'd255);
      checkOutput("m_last_data", logData[255], 16'h10FF);
    end
    badSeq = 0;
    foreach (logAddr[k]) begin
      if (logAddr[k] !== 16'(k) || logData[k] !== 16'h1000 + 16'(k)) badSeq++;
    end
    checkOutput("m_seq", badSeq, 0);

    // Asynchronous reset in the middle of a five-word load
    applyStimulus(16'd5);
    in_valid = 1'b1;
    in_data  = 16'h0E01;
    step();
    in_data  = 16'h0E02;
    step();
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("mr_wr",    mem_wr, 0);
    checkOutput("mr_addr",  mem_addr, 0);
    checkOutput("mr_data",  mem_data, 0);
    checkOutput("mr_prst",  proc_resetn, 0);
    checkOutput("mr_ready", in_ready, 0);
    checkOutput("mr_busy",  busy, 0);
    checkOutput("mr_done",  done, 0);
    logAddr.delete();
    logData.delete();
    step();
    resetn = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    checkOutput("mr_nowr",  logAddr.size(), 0);
    checkOutput("mr_idle",  in_ready, 0);
    applyStimulus(16'd1);
    in_valid = 1'b1;
    in_data  = 16'h0077;
    step();
    in_valid = 1'b0;
    checkOutput("mr_re_wr",   mem_wr, 1);
    checkOutput("mr_re_addr", mem_addr, 0);
    checkOutput("mr_re_data", mem_data, 16'h0077);
    waitRelease("mr");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
